// File: rtl/u712_sdram_arb.sv
// u712_sdram_arb: chip RAM SDRAM arbiter for Agnus DMA, CPU and refresh.
// Issues ACTIVE / READ|WRITE / PRECHARGE sequences for one owner at a time,
// and interleaves auto-refresh driven by a free-running interval timer.
module u712_sdram_arb #(
    parameter int REF_INTERVAL = 624,
    parameter int TRCD         = 2,
    parameter int CL           = 2,
    parameter int TRP          = 2,
    parameter int TRFC         = 6
) (
    input  logic       CLK80,
    input  logic       RESETn,
    input  logic       DMA_REQ,
    input  logic       DMA_WR,
    input  logic       CPU_REQ,
    input  logic       CPU_WR,
    output logic [2:0] CMD,
    output logic       ADDR_SEL,
    output logic       DMA_GNT,
    output logic       CPU_GNT,
    output logic       DMA_ACK,
    output logic       CPU_ACK,
    output logic [1:0] REF_PEND
);

    // SDRAM command encodings {RASn,CASn,WEn}
    localparam logic [2:0] CMD_NOP     = 3'b111;
    localparam logic [2:0] CMD_ACTIVE  = 3'b011;
    localparam logic [2:0] CMD_READ    = 3'b101;
    localparam logic [2:0] CMD_WRITE   = 3'b100;
    localparam logic [2:0] CMD_PRECHG  = 3'b010;
    localparam logic [2:0] CMD_REFRESH = 3'b001;

    // Sequence counter must hold the largest reload value
    localparam int CNT_MAX_A = (TRCD > CL) ? TRCD : CL;
    localparam int CNT_MAX_B = (TRP > TRFC) ? TRP : TRFC;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TRCD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] C_CL   = CNT_W'(CL);
    localparam logic [CNT_W-1:0] C_TRP  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] C_TRFC = CNT_W'(TRFC - 1);

    localparam int TMR_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] C_TMR_INIT = TMR_W'(REF_INTERVAL - 1);
    localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACT      = 3'd1,
        RW       = 3'd2,
        CAS_WAIT = 3'd3,
        PRE      = 3'd4,
        REF      = 3'd5
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_cmd;
    logic               r_addr_sel;
    logic [1:0]         r_gnt;       // {DMA, CPU}
    logic [1:0]         r_ack;       // {DMA, CPU}
    logic               r_wr;        // direction latched at the ACTIVE edge
    logic [TMR_W-1:0]   r_tmr;
    logic [1:0]         r_ref_pend;

    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [2:0]         w_cmd_next;
    logic               w_addr_sel_next;
    logic [1:0]         w_gnt_next;
    logic [1:0]         w_ack_next;
    logic               w_wr_next;

    logic               w_idle;
    logic               w_urgent;
    logic               w_sel_ref;
    logic               w_sel_dma;
    logic               w_sel_cpu;
    logic               w_ref_grant;
    logic               w_expire;

    // PRE and REF behave as IDLE on their final edge so a new access can
    // start on the very edge the previous one finishes.
    assign w_idle      = (r_state == IDLE) ||
                         (((r_state == PRE) || (r_state == REF)) && (r_cnt == '0));
    assign w_urgent    = (r_ref_pend >= 2'd2);
    assign w_sel_ref   = w_urgent || (!DMA_REQ && !CPU_REQ && (r_ref_pend != 2'd0));
    assign w_sel_dma   = !w_urgent && DMA_REQ;
    assign w_sel_cpu   = !w_urgent && !DMA_REQ && CPU_REQ;
    assign w_ref_grant = w_idle && w_sel_ref;
    assign w_expire    = (r_tmr == '0);

    // State register and registered outputs; reset abandons any sequence
    always_ff @(negedge CLK80) begin
        if (!RESETn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cmd      <= CMD_NOP;
            r_addr_sel <= 1'b0;
            r_gnt      <= 2'b00;
            r_ack      <= 2'b00;
            r_wr       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_cmd      <= w_cmd_next;
            r_addr_sel <= w_addr_sel_next;
            r_gnt      <= w_gnt_next;
            r_ack      <= w_ack_next;
            r_wr       <= w_wr_next;
        end
    end

    // Next-state logic: sequence timing and arbitration on idle edges
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ACT: begin
                if (r_cnt == '0) begin
                    w_state_next = r_wr ? RW : CAS_WAIT;
                    w_cnt_next   = r_wr ? '0 : C_CL;
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            RW: begin
                w_state_next = PRE;
                w_cnt_next   = C_TRP;
            end
            CAS_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = PRE;
                    w_cnt_next   = C_TRP;
                end else begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            PRE, REF: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - C_ONE;
                end
            end
            default: ;
        endcase
        if (w_idle) begin
            if (w_sel_ref) begin
                w_state_next = REF;
                w_cnt_next   = C_TRFC;
            end else if (w_sel_dma || w_sel_cpu) begin
                w_state_next = ACT;
                w_cnt_next   = C_TRCD;
            end else begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        end
    end

    // Output logic: command, address mux, grant and ack for the next edge
    always_comb begin
        w_cmd_next      = CMD_NOP;
        w_addr_sel_next = r_addr_sel;
        w_gnt_next      = r_gnt;
        w_ack_next      = 2'b00;
        w_wr_next       = r_wr;
        case (r_state)
            ACT: begin
                if (r_cnt == '0) begin
                    w_cmd_next      = r_wr ? CMD_WRITE : CMD_READ;
                    w_addr_sel_next = 1'b1;
                    if (r_wr) begin
                        w_ack_next = r_gnt;
                    end
                end
            end
            RW: begin
                w_cmd_next = CMD_PRECHG;
            end
            CAS_WAIT: begin
                if (r_cnt == C_ONE) begin
                    w_ack_next = r_gnt;
                end else if (r_cnt == '0) begin
                    w_cmd_next = CMD_PRECHG;
                end
            end
            default: ;
        endcase
        if (w_idle) begin
            w_addr_sel_next = 1'b0;
            w_gnt_next      = {w_sel_dma, w_sel_cpu};
            if (w_sel_ref) begin
                w_cmd_next = CMD_REFRESH;
            end else if (w_sel_dma) begin
                w_cmd_next = CMD_ACTIVE;
                w_wr_next  = DMA_WR;
            end else if (w_sel_cpu) begin
                w_cmd_next = CMD_ACTIVE;
                w_wr_next  = CPU_WR;
            end
        end
    end

    // Refresh interval timer and saturating count of owed refreshes
    always_ff @(negedge CLK80) begin
        if (!RESETn) begin
            r_tmr      <= C_TMR_INIT;
            r_ref_pend <= 2'd0;
        end else begin
            r_tmr <= w_expire ? C_TMR_INIT : (r_tmr - C_TMR_ONE);
            if (w_expire && !w_ref_grant) begin
                if (r_ref_pend != 2'd3) begin
                    r_ref_pend <= r_ref_pend + 2'd1;
                end
            end else if (w_ref_grant && !w_expire) begin
                r_ref_pend <= r_ref_pend - 2'd1;
            end
        end
    end

    assign CMD      = r_cmd;
    assign ADDR_SEL = r_addr_sel;
    assign DMA_GNT  = r_gnt[1];
    assign CPU_GNT  = r_gnt[0];
    assign DMA_ACK  = r_ack[1];
    assign CPU_ACK  = r_ack[0];
    assign REF_PEND = r_ref_pend;

endmodule

// File: tb/tb_u712_sdram_arb.sv
// Bench for u712_sdram_arb: directed accesses with a scoreboard of expected
// output events, plus a short-interval instance to exercise refresh backlog.
`timescale 1ns/1ps
module tb_u712_sdram_arb;

    localparam logic [2:0] C_NOP = 3'b111;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;

    logic       CLK80;
    logic       RESETn, DMA_REQ, DMA_WR, CPU_REQ, CPU_WR;
    logic [2:0] CMD;
    logic       ADDR_SEL, DMA_GNT, CPU_GNT, DMA_ACK, CPU_ACK;
    logic [1:0] REF_PEND;

    logic       sat_rstn;
    logic       sat_dma_req, sat_dma_wr, sat_cpu_req, sat_cpu_wr;
    logic [2:0] sat_cmd;
    logic       sat_addr_sel, sat_dma_gnt, sat_cpu_gnt, sat_dma_ack, sat_cpu_ack;
    logic [1:0] sat_ref_pend;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    bit mon_en = 1'b0;
    bit sat_done = 1'b0;

    typedef struct {
        int         edge_no;
        logic [2:0] cmd;
        logic [1:0] gnt;
        logic       as;
        logic [1:0] ack;
        logic [1:0] pend;
    } ev_t;

    ev_t exp_q[$];

    u712_sdram_arb u_dut (
        .CLK80(CLK80), .RESETn(RESETn),
        .DMA_REQ(DMA_REQ), .DMA_WR(DMA_WR), .CPU_REQ(CPU_REQ), .CPU_WR(CPU_WR),
        .CMD(CMD), .ADDR_SEL(ADDR_SEL), .DMA_GNT(DMA_GNT), .CPU_GNT(CPU_GNT),
        .DMA_ACK(DMA_ACK), .CPU_ACK(CPU_ACK), .REF_PEND(REF_PEND)
    );

    u712_sdram_arb #(.REF_INTERVAL(4), .TRFC(19)) u_sat (
        .CLK80(CLK80), .RESETn(sat_rstn),
        .DMA_REQ(sat_dma_req), .DMA_WR(sat_dma_wr), .CPU_REQ(sat_cpu_req), .CPU_WR(sat_cpu_wr),
        .CMD(sat_cmd), .ADDR_SEL(sat_addr_sel), .DMA_GNT(sat_dma_gnt), .CPU_GNT(sat_cpu_gnt),
        .DMA_ACK(sat_dma_ack), .CPU_ACK(sat_cpu_ack), .REF_PEND(sat_ref_pend)
    );

    initial begin
        CLK80 = 1'b1;
        forever #5 CLK80 = ~CLK80;
    end

    // edge_n is the number of the most recent active (falling) edge
    always @(negedge CLK80) edge_n <= edge_n + 1;

    task automatic push(input int e, input logic [2:0] c, input logic [1:0] g,
                        input logic a, input logic [1:0] k, input logic [1:0] p);
        ev_t ev;
        ev.edge_no = e; ev.cmd = c; ev.gnt = g; ev.as = a; ev.ack = k; ev.pend = p;
        exp_q.push_back(ev);
    endtask

    task automatic wait_edge(input int target);
        while (edge_n < target) @(posedge CLK80);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", name, got, want, edge_n);
        end
    endtask

    // Expected refresh backlog during the long DMA run (offset from release)
    function automatic logic [1:0] pend_at(input int off);
        return 2'((off >= 623 ? 1 : 0) + (off >= 1247 ? 1 : 0));
    endfunction

    // Monitor: every non-NOP command, ACK pulse or grant change is an event
    logic [1:0] prev_gnt = 2'b00;
    logic [1:0] cur_gnt;
    ev_t        mon_ev;
    always @(posedge CLK80) begin
        cur_gnt = {DMA_GNT, CPU_GNT};
        if (mon_en) begin
            if (CMD !== C_NOP || DMA_ACK !== 1'b0 || CPU_ACK !== 1'b0 || cur_gnt !== prev_gnt) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event edge=%0d cmd=%b gnt=%b as=%b ack=%b%b pend=%0d required=none",
                             edge_n, CMD, cur_gnt, ADDR_SEL, DMA_ACK, CPU_ACK, REF_PEND);
                end else begin
                    mon_ev = exp_q.pop_front();
                    if (mon_ev.edge_no != edge_n || mon_ev.cmd !== CMD || mon_ev.gnt !== cur_gnt ||
                        mon_ev.as !== ADDR_SEL || mon_ev.ack !== {DMA_ACK, CPU_ACK} ||
                        mon_ev.pend !== REF_PEND) begin
                        errors++;
                        $display("FAIL event got edge=%0d cmd=%b gnt=%b as=%b ack=%b%b pend=%0d required edge=%0d cmd=%b gnt=%b as=%b ack=%b pend=%0d",
                                 edge_n, CMD, cur_gnt, ADDR_SEL, DMA_ACK, CPU_ACK, REF_PEND,
                                 mon_ev.edge_no, mon_ev.cmd, mon_ev.gnt, mon_ev.as, mon_ev.ack, mon_ev.pend);
                    end else begin
                        $display("event edge=%0d cmd=%b gnt=%b as=%b ack=%b%b pend=%0d ok",
                                 edge_n, CMD, cur_gnt, ADDR_SEL, DMA_ACK, CPU_ACK, REF_PEND);
                    end
                end
            end
            checks++;
            if ((DMA_GNT && CPU_GNT) || (DMA_ACK && CPU_ACK)) begin
                errors++;
                $display("FAIL onehot edge=%0d gnt=%b ack=%b%b required one-hot or zero",
                         edge_n, cur_gnt, DMA_ACK, CPU_ACK);
            end
        end
        prev_gnt = cur_gnt;
    end

    // Short-interval instance: refresh backlog builds faster than it drains
    int         sat_off  [11] = '{2, 3, 4, 7, 11, 15, 19, 23, 24, 42, 43};
    logic [1:0] sat_pexp [11] = '{0, 1, 0, 1, 2, 3, 3, 3, 3, 2, 3};
    logic [2:0] sat_cexp [11] = '{C_NOP, C_NOP, C_REF, C_NOP, C_NOP, C_NOP, C_NOP, C_REF, C_NOP, C_REF, C_NOP};
    initial begin
        int s0;
        sat_rstn = 1'b0;
        sat_dma_req = 1'b0; sat_dma_wr = 1'b0; sat_cpu_req = 1'b0; sat_cpu_wr = 1'b0;
        repeat (2) @(posedge CLK80);
        sat_rstn = 1'b1;
        s0 = edge_n + 1;
        for (int i = 0; i < 11; i++) begin
            wait_edge(s0 + sat_off[i]);
            chk($sformatf("sat_pend_e%0d", sat_off[i]), int'(sat_ref_pend), int'(sat_pexp[i]));
            chk($sformatf("sat_cmd_e%0d", sat_off[i]), int'(sat_cmd), int'(sat_cexp[i]));
            $display("sat edge=+%0d cmd=%b pend=%0d", sat_off[i], sat_cmd, sat_ref_pend);
        end
        sat_done = 1'b1;
    end

    // Stimulus
    initial begin
        int e0, e1, r0;
        RESETn = 1'b0; DMA_REQ = 1'b0; DMA_WR = 1'b0; CPU_REQ = 1'b0; CPU_WR = 1'b0;
        repeat (3) @(posedge CLK80);
        chk("rst_cmd", int'(CMD), int'(C_NOP));
        chk("rst_addr_sel", int'(ADDR_SEL), 0);
        chk("rst_gnt", int'({DMA_GNT, CPU_GNT}), 0);
        chk("rst_ack", int'({DMA_ACK, CPU_ACK}), 0);
        chk("rst_pend", int'(REF_PEND), 0);
        RESETn = 1'b1;
        mon_en = 1'b1;

        // CPU read granted on the first released edge; request and direction
        // change right after the grant must not disturb the access
        e0 = edge_n + 1;
        CPU_REQ = 1'b1; CPU_WR = 1'b0;
        push(e0,     C_ACT, 2'b01, 1'b0, 2'b00, 2'd0);
        push(e0 + 2, C_RD,  2'b01, 1'b1, 2'b00, 2'd0);
        push(e0 + 4, C_NOP, 2'b01, 1'b1, 2'b01, 2'd0);
        push(e0 + 5, C_PRE, 2'b01, 1'b1, 2'b00, 2'd0);
        push(e0 + 7, C_NOP, 2'b00, 1'b0, 2'b00, 2'd0);
        wait_edge(e0);
        CPU_REQ = 1'b0; CPU_WR = 1'b1;
        wait_edge(e0 + 9);

        // DMA write alone
        e0 = edge_n + 1;
        DMA_REQ = 1'b1; DMA_WR = 1'b1; CPU_WR = 1'b0;
        push(e0,     C_ACT, 2'b10, 1'b0, 2'b00, 2'd0);
        push(e0 + 2, C_WR,  2'b10, 1'b1, 2'b10, 2'd0);
        push(e0 + 3, C_PRE, 2'b10, 1'b1, 2'b00, 2'd0);
        push(e0 + 5, C_NOP, 2'b00, 1'b0, 2'b00, 2'd0);
        wait_edge(e0);
        DMA_REQ = 1'b0; DMA_WR = 1'b0;
        wait_edge(e0 + 8);

        // Simultaneous DMA read and CPU write: DMA first, CPU on the return edge
        e0 = edge_n + 1;
        e1 = e0 + 7;
        DMA_REQ = 1'b1; DMA_WR = 1'b0; CPU_REQ = 1'b1; CPU_WR = 1'b1;
        push(e0,     C_ACT, 2'b10, 1'b0, 2'b00, 2'd0);
        push(e0 + 2, C_RD,  2'b10, 1'b1, 2'b00, 2'd0);
        push(e0 + 4, C_NOP, 2'b10, 1'b1, 2'b10, 2'd0);
        push(e0 + 5, C_PRE, 2'b10, 1'b1, 2'b00, 2'd0);
        push(e1,     C_ACT, 2'b01, 1'b0, 2'b00, 2'd0);
        push(e1 + 2, C_WR,  2'b01, 1'b1, 2'b01, 2'd0);
        push(e1 + 3, C_PRE, 2'b01, 1'b1, 2'b00, 2'd0);
        push(e1 + 5, C_NOP, 2'b00, 1'b0, 2'b00, 2'd0);
        wait_edge(e0);
        DMA_REQ = 1'b0; DMA_WR = 1'b1;
        wait_edge(e1);
        CPU_REQ = 1'b0; CPU_WR = 1'b0;
        wait_edge(e1 + 8);

        // Reset on edge e1 of a CPU read: sequence abandoned, no ACK
        e0 = edge_n + 1;
        CPU_REQ = 1'b1; CPU_WR = 1'b0;
        push(e0,     C_ACT, 2'b01, 1'b0, 2'b00, 2'd0);
        push(e0 + 1, C_NOP, 2'b00, 1'b0, 2'b00, 2'd0);
        wait_edge(e0);
        RESETn = 1'b0; CPU_REQ = 1'b0;
        wait_edge(e0 + 1);
        chk("midrst_cmd", int'(CMD), int'(C_NOP));
        chk("midrst_cpu_gnt", int'(CPU_GNT), 0);
        chk("midrst_pend", int'(REF_PEND), 0);
        wait_edge(e0 + 2);
        RESETn = 1'b1;
        wait_edge(e0 + 12);

        // DMA writes held continuously: refresh waits until two are owed
        RESETn = 1'b0;
        DMA_REQ = 1'b1; DMA_WR = 1'b1;
        wait_edge(edge_n + 2);
        RESETn = 1'b1;
        r0 = edge_n + 1;
        for (int k = 0; k < 250; k++) begin
            push(r0 + 5 * k,     C_ACT, 2'b10, 1'b0, 2'b00, pend_at(5 * k));
            push(r0 + 5 * k + 2, C_WR,  2'b10, 1'b1, 2'b10, pend_at(5 * k + 2));
            push(r0 + 5 * k + 3, C_PRE, 2'b10, 1'b1, 2'b00, pend_at(5 * k + 3));
        end
        push(r0 + 1250, C_REF, 2'b00, 1'b0, 2'b00, 2'd1);
        push(r0 + 1256, C_ACT, 2'b10, 1'b0, 2'b00, 2'd1);
        push(r0 + 1258, C_WR,  2'b10, 1'b1, 2'b10, 2'd1);
        push(r0 + 1259, C_PRE, 2'b10, 1'b1, 2'b00, 2'd1);
        push(r0 + 1261, C_REF, 2'b00, 1'b0, 2'b00, 2'd0);
        wait_edge(r0 + 1248);
        chk("pend_two_before_ref", int'(REF_PEND), 2);
        wait_edge(r0 + 1256);
        DMA_REQ = 1'b0; DMA_WR = 1'b0;
        wait_edge(r0 + 1280);

        chk("sat_done", int'(sat_done), 1);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
